matmul_job_arbiter: RTL
=======================

MATMUL_JOB_ARBITER -- requirements
Module: matmul_job_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one matrix_multiply engine.
REQ-002 Parameter SIZE_WIDTH, 3, dimension field width; each field holds last index (dimension minus 1).
REQ-003 Parameter ADDR_WIDTH, 32, memory address width.
REQ-004 Parameter TIMEOUT_CYCLES, 4096, watchdog limit per job.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 req_valid  in  NUM_REQ  per-requester job request.
REQ-009 req_desc  in  NUM_REQ x (4*SIZE_WIDTH+3*ADDR_WIDTH)  per-requester {c_base,b_base,a_base,b_cols,b_rows,a_cols,a_rows}, a_rows in LSBs.
REQ-010 req_ready  out  NUM_REQ  one-hot accept; transfer when valid&ready.
REQ-011 rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to owning requester.
REQ-012 rsp_code  out  2  00 ok, 01 dimension mismatch, 10 timeout; valid with rsp_valid.
REQ-013 mm_start  out  1  one-cycle start pulse to engine.
REQ-014 mm_a_size / mm_b_size  out  2xSIZE_WIDTH each  {cols,rows} of latched job.
REQ-015 mm_busy  in  1  engine busy.
REQ-016 mm_a_address / mm_b_address / mm_c_address  in  ADDR_WIDTH each  engine-relative addresses.
REQ-017 mm_c_write  in  1  engine write strobe.
REQ-018 mem_a_address / mem_b_address / mem_c_address  out  ADDR_WIDTH each  translated addresses.
REQ-019 mem_c_write  out  1  gated write strobe.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 FSM states IDLE, CHECK, LAUNCH, WAIT_ACK, RUN, RESP.
REQ-022 IDLE: if any req_valid, combinationally grant round-robin starting at last_grant+1 (mod NUM_REQ), assert that req_ready bit same cycle, latch req_desc and grant id, go CHECK; else stay.
REQ-023 req_ready SHALL be zero in all states except IDLE; exactly one job accepted per pass through IDLE.
REQ-024 last_grant SHALL update to the granted id on acceptance.
REQ-025 CHECK (1 cycle): a_cols != b_rows -> RESP with code 01, no mm_start; else -> LAUNCH.
REQ-026 LAUNCH: mm_start=1 for exactly this cycle; clear watchdog; -> WAIT_ACK.
REQ-027 WAIT_ACK: mm_busy=1 -> RUN; low mm_busy is ignored.
REQ-028 RUN: mm_busy=0 -> RESP with code 00.
REQ-029 Watchdog increments each cycle in WAIT_ACK and RUN; at count TIMEOUT_CYCLES-1 -> RESP with code 10, overriding same-cycle busy transitions.
REQ-030 RESP (1 cycle): rsp_valid[grant]=1, rsp_code driven; -> IDLE.
REQ-031 mm_a_size/mm_b_size driven from latched descriptor in all non-IDLE states, zero in IDLE.
REQ-032 mem_x_address = x_base + mm_x_address, modulo 2^ADDR_WIDTH, combinational, in RUN; zero otherwise.
REQ-033 mem_c_write = mm_c_write AND state==RUN.
REQ-034 Latency: accept at cycle T; mm_start at T+2; mismatch response at T+2; earliest ok response one cycle after mm_busy falls.
REQ-035 req_valid deasserting while not granted is legal; no requester is granted twice before every other continuously-valid requester is granted once.

Reset
REQ-036 reset low SHALL immediately force IDLE, all outputs 0, watchdog 0, last_grant=NUM_REQ-1 (requester 0 first).
REQ-037 Reset mid-job SHALL drop the job without rsp_valid; no mm_start after release until a new acceptance.

Verification
REQ-038 req_valid=0001, desc a=3x3(2,2) b=3x3(2,2); engine busy 10 cycles -> req_ready=0001, mm_start at T+2, rsp_valid=0001 code 00.
REQ-039 req_valid=1111 held through 4 jobs from reset -> grant order 0,1,2,3, each rsp_valid matches its grant.
REQ-040 a_cols=2, b_rows=1 -> no mm_start, rsp_code 01 at T+2.
REQ-041 mm_busy stuck 0 after start, TIMEOUT_CYCLES=16 -> rsp_code 10, busy falls next cycle.
REQ-042 a_base=0x1000, mm_a_address=0x5 in RUN -> mem_a_address=0x1005; mm_c_write in IDLE -> mem_c_write=0.
REQ-043 reset asserted in RUN -> all outputs 0 same cycle, no rsp_valid after release.

Source files
------------

// File: rtl/matmul_job_arbiter.sv
// Shares one matrix_multiply engine among NUM_REQ requesters: round-robin acceptance,
// dimension check, watchdog-supervised run, and base-relative address translation.
module matmul_job_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int SIZE_WIDTH     = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [NUM_REQ-1:0]                                req_valid,
  input  logic [NUM_REQ-1:0][4*SIZE_WIDTH+3*ADDR_WIDTH-1:0] req_desc,
  output logic [NUM_REQ-1:0]                                req_ready,
  output logic [NUM_REQ-1:0]                                rsp_valid,
  output logic [1:0]                                        rsp_code,
  output logic                                              mm_start,
  output logic [2*SIZE_WIDTH-1:0]                           mm_a_size,
  output logic [2*SIZE_WIDTH-1:0]                           mm_b_size,
  input  logic                                              mm_busy,
  input  logic [ADDR_WIDTH-1:0]                             mm_a_address,
  input  logic [ADDR_WIDTH-1:0]                             mm_b_address,
  input  logic [ADDR_WIDTH-1:0]                             mm_c_address,
  input  logic                                              mm_c_write,
  output logic [ADDR_WIDTH-1:0]                             mem_a_address,
  output logic [ADDR_WIDTH-1:0]                             mem_b_address,
  output logic [ADDR_WIDTH-1:0]                             mem_c_address,
  output logic                                              mem_c_write,
  output logic                                              busy
);

  localparam int DESC_W = 4*SIZE_WIDTH + 3*ADDR_WIDTH;
  localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0]   GRANT_INIT = GW'(NUM_REQ - 1);
  localparam logic [1:0] CODE_OK  = 2'b00;
  localparam logic [1:0] CODE_DIM = 2'b01;
  localparam logic [1:0] CODE_TMO = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_LAUNCH   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_RUN      = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

  state_t              state_r, state_s;
  logic [DESC_W-1:0]   desc_r;
  logic [GW-1:0]       grant_r, last_grant_r, grant_s;
  logic                grant_vld_s;
  logic [WD_W-1:0]     wd_r;
  logic [1:0]          code_r, code_s;
  logic [SIZE_WIDTH-1:0] a_cols_s, b_rows_s;
  logic [ADDR_WIDTH-1:0] a_base_s, b_base_s, c_base_s;
  logic                in_run_s;

  assign a_cols_s = desc_r[2*SIZE_WIDTH-1:SIZE_WIDTH];
  assign b_rows_s = desc_r[3*SIZE_WIDTH-1:2*SIZE_WIDTH];
  assign a_base_s = desc_r[4*SIZE_WIDTH +: ADDR_WIDTH];
  assign b_base_s = desc_r[4*SIZE_WIDTH+ADDR_WIDTH +: ADDR_WIDTH];
  assign c_base_s = desc_r[4*SIZE_WIDTH+2*ADDR_WIDTH +: ADDR_WIDTH];
  assign in_run_s = (state_r == ST_RUN);

  // Round-robin pick: first valid requester after the last one granted
  always_comb begin
    grant_s     = last_grant_r;
    grant_vld_s = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!grant_vld_s && req_valid[GW'((int'(last_grant_r) + i) % NUM_REQ)]) begin
        grant_vld_s = 1'b1;
        grant_s     = GW'((int'(last_grant_r) + i) % NUM_REQ);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Next-state and response-code selection; the watchdog wins over busy edges
  always_comb begin
    state_s = state_r;
    code_s  = code_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_vld_s) state_s = ST_CHECK;
        else             state_s = ST_IDLE;
      end
      ST_CHECK: begin
        if (a_cols_s != b_rows_s) begin
          state_s = ST_RESP;
          code_s  = CODE_DIM;
        end else begin
          state_s = ST_LAUNCH;
          code_s  = CODE_OK;
        end
      end
      ST_LAUNCH: state_s = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (wd_r == WD_LAST) begin
          state_s = ST_RESP;
          code_s  = CODE_TMO;
        end else if (mm_busy) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_WAIT_ACK;
        end
      end
      ST_RUN: begin
        if (wd_r == WD_LAST) begin
          state_s = ST_RESP;
          code_s  = CODE_TMO;
        end else if (!mm_busy) begin
          state_s = ST_RESP;
          code_s  = CODE_OK;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register plus the job latched on acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      code_r       <= CODE_OK;
      desc_r       <= {DESC_W{1'b0}};
      grant_r      <= {GW{1'b0}};
      last_grant_r <= GRANT_INIT;
    end else begin
      state_r <= state_s;
      code_r  <= code_s;
      if (state_r == ST_IDLE && grant_vld_s) begin
        desc_r       <= req_desc[grant_s];
        grant_r      <= grant_s;
        last_grant_r <= grant_s;
      end
    end
  end

  // Watchdog: restarted at launch, counts while waiting on or running the engine
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_r <= {WD_W{1'b0}};
    end else if (state_r == ST_LAUNCH) begin
      wd_r <= {WD_W{1'b0}};
    end else if (state_r == ST_WAIT_ACK || state_r == ST_RUN) begin
      wd_r <= wd_r + WD_W'(1);
    end else begin
      wd_r <= wd_r;
    end
  end

  // Output decode; req_ready is also gated by reset so nothing is offered while held
  always_comb begin
    req_ready     = {NUM_REQ{1'b0}};
    rsp_valid     = {NUM_REQ{1'b0}};
    rsp_code      = 2'b00;
    mm_start      = 1'b0;
    mm_a_size     = {(2*SIZE_WIDTH){1'b0}};
    mm_b_size     = {(2*SIZE_WIDTH){1'b0}};
    mem_a_address = {ADDR_WIDTH{1'b0}};
    mem_b_address = {ADDR_WIDTH{1'b0}};
    mem_c_address = {ADDR_WIDTH{1'b0}};
    mem_c_write   = 1'b0;
    busy          = 1'b0;
    if (state_r == ST_IDLE) begin
      if (grant_vld_s && reset) req_ready = NUM_REQ'(1) << grant_s;
      else                      req_ready = {NUM_REQ{1'b0}};
    end else begin
      busy      = 1'b1;
      mm_a_size = desc_r[2*SIZE_WIDTH-1:0];
      mm_b_size = desc_r[4*SIZE_WIDTH-1:2*SIZE_WIDTH];
    end
    if (state_r == ST_RESP) begin
      rsp_valid = NUM_REQ'(1) << grant_r;
      rsp_code  = code_r;
    end else begin
      rsp_valid = {NUM_REQ{1'b0}};
    end
    if (state_r == ST_LAUNCH) mm_start = 1'b1;
    else                      mm_start = 1'b0;
    if (in_run_s) begin
      mem_a_address = a_base_s + mm_a_address;
      mem_b_address = b_base_s + mm_b_address;
      mem_c_address = c_base_s + mm_c_address;
      mem_c_write   = mm_c_write;
    end else begin
      mem_c_write   = 1'b0;
    end
  end

endmodule
